// File: rtl/id_stage_pkg.sv
// Shared decode constants: opcodes, funct codes, ALU op encoding, immediate formats.
package id_stage_pkg;

   // Base integer opcodes (inst[6:0])
   localparam logic [6:0] INST_TYPE_LOAD      = 7'h03;
   localparam logic [6:0] INST_TYPE_OP_IMM    = 7'h13;
   localparam logic [6:0] INST_TYPE_AUIPC     = 7'h17;
   localparam logic [6:0] INST_TYPE_OP_IMM_32 = 7'h1B;
   localparam logic [6:0] INST_TYPE_STORE     = 7'h23;
   localparam logic [6:0] INST_TYPE_OP        = 7'h33;
   localparam logic [6:0] INST_TYPE_LUI       = 7'h37;
   localparam logic [6:0] INST_TYPE_OP_32     = 7'h3B;
   localparam logic [6:0] INST_TYPE_BRANCH    = 7'h63;
   localparam logic [6:0] INST_TYPE_JALR      = 7'h67;
   localparam logic [6:0] INST_TYPE_JAL       = 7'h6F;

   // funct3 / funct7 codes
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [6:0] F7_BASE    = 7'h00;
   localparam logic [6:0] F7_ALT     = 7'h20;

   // ALU op encoding; bit 4 marks a 32-bit (*W) operation
   localparam logic [4:0] ALU_OP_ADD    = 5'd0;
   localparam logic [4:0] ALU_OP_SUB    = 5'd1;
   localparam logic [4:0] ALU_OP_SLL    = 5'd2;
   localparam logic [4:0] ALU_OP_SLT    = 5'd3;
   localparam logic [4:0] ALU_OP_SLTU   = 5'd4;
   localparam logic [4:0] ALU_OP_XOR    = 5'd5;
   localparam logic [4:0] ALU_OP_SRL    = 5'd6;
   localparam logic [4:0] ALU_OP_SRA    = 5'd7;
   localparam logic [4:0] ALU_OP_OR     = 5'd8;
   localparam logic [4:0] ALU_OP_AND    = 5'd9;
   localparam logic [4:0] ALU_OP_BEQ    = 5'd10;
   localparam logic [4:0] ALU_OP_BNE    = 5'd11;
   localparam logic [4:0] ALU_OP_BLT    = 5'd12;
   localparam logic [4:0] ALU_OP_BGE    = 5'd13;
   localparam logic [4:0] ALU_OP_BLTU   = 5'd14;
   localparam logic [4:0] ALU_OP_BGEU   = 5'd15;
   localparam logic [4:0] ALU_OP_W_FLAG = 5'h10;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
   typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;

   // Register/immediate arithmetic op from funct3; alt selects SUB/SRA
   function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      logic [4:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_OP_SUB : ALU_OP_ADD;
         3'b001:  op = ALU_OP_SLL;
         3'b010:  op = ALU_OP_SLT;
         3'b011:  op = ALU_OP_SLTU;
         3'b100:  op = ALU_OP_XOR;
         3'b101:  op = alt ? ALU_OP_SRA : ALU_OP_SRL;
         3'b110:  op = ALU_OP_OR;
         default: op = ALU_OP_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decoded-instruction bus from the decode stage to EX, with valid/ready handshake.
interface id_stage_if #(
   parameter int XLEN     = 64,
   parameter int ALU_OP_W = 5
);
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         inst_o;
   logic [XLEN-1:0]     inst_addr_o;
   logic [XLEN-1:0]     op1_o;
   logic [XLEN-1:0]     op2_o;
   logic [XLEN-1:0]     imm_o;
   logic [4:0]          rd_addr_o;
   logic                reg_wen_o;
   logic [ALU_OP_W-1:0] alu_op_o;
   logic                illegal_o;

   modport master (
      output out_valid, inst_o, inst_addr_o, op1_o, op2_o, imm_o,
             rd_addr_o, reg_wen_o, alu_op_o, illegal_o,
      input  out_ready
   );

   modport slave (
      input  out_valid, inst_o, inst_addr_o, op1_o, op2_o, imm_o,
             rd_addr_o, reg_wen_o, alu_op_o, illegal_o,
      output out_ready
   );
endinterface

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate and sign-extends from bit 31.
module id_stage_imm_gen
   import id_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     inst_i,
   input  imm_fmt_e        fmt_i,
   output logic [XLEN-1:0] imm_o
);
   logic [31:0] imm32;
   logic        unused_opcode;

   // The opcode field never contributes to an immediate
   assign unused_opcode = ^inst_i[6:0];

   // Assemble the 32-bit immediate for the selected format
   always_comb begin
      imm32 = '0;
      case (fmt_i)
         IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
         IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
         IMM_U:   imm32 = {inst_i[31:12], 12'b0};
         IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/id_stage.sv
// Decode stage: RV32I/RV64I decode, operand mux, load-use hazard stall and output register.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int ALU_OP_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] inst_addr_i,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            ex_load_i,
   input  logic [4:0]      ex_rd_i,
   input  logic            flush_i,
   id_stage_if.master      out_if
);
   localparam bit RV64 = (XLEN == 64);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       ill_d, rs1_used, rs2_used, wen_cls, op2_imm;
   imm_fmt_e   fmt;
   op1_sel_e   op1_sel;
   logic [4:0] alu5;

   logic [XLEN-1:0]     imm_d, op1_d, op2_d;
   logic [4:0]          rd_d;
   logic                wen_d, hazard, accept;

   logic                valid_q, wen_q, ill_q;
   logic [31:0]         inst_q;
   logic [XLEN-1:0]     addr_q, op1_q, op2_q, imm_q;
   logic [4:0]          rd_q;
   logic [ALU_OP_W-1:0] alu_q;

   assign opcode = inst_i[6:0];
   assign f3     = inst_i[14:12];
   assign f7     = inst_i[31:25];

   // Instruction decode: legality, register usage, immediate format and ALU op
   always_comb begin
      ill_d    = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      wen_cls  = 1'b0;
      op2_imm  = 1'b0;
      fmt      = IMM_NONE;
      op1_sel  = OP1_RS1;
      alu5     = ALU_OP_ADD;
      case (opcode)
         INST_TYPE_OP: begin
            rs1_used = 1'b1; rs2_used = 1'b1; wen_cls = 1'b1;
            if (f7 == F7_BASE)
               alu5 = alu_from_f3(f3, 1'b0);
            else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))
               alu5 = alu_from_f3(f3, 1'b1);
            else
               ill_d = 1'b1;
         end
         INST_TYPE_OP_IMM: begin
            rs1_used = 1'b1; wen_cls = 1'b1; fmt = IMM_I; op2_imm = 1'b1;
            alu5 = alu_from_f3(f3, 1'b0);
            // Shift amounts are 6 bits wide on RV64, 5 bits on RV32
            if (f3 == F3_SLL) begin
               if (inst_i[31:26] != 6'b000000 || (!RV64 && inst_i[25])) ill_d = 1'b1;
            end else if (f3 == F3_SRL_SRA) begin
               if ((inst_i[31:26] != 6'b000000 && inst_i[31:26] != 6'b010000) || (!RV64 && inst_i[25]))
                  ill_d = 1'b1;
               alu5 = inst_i[30] ? ALU_OP_SRA : ALU_OP_SRL;
            end
         end
         INST_TYPE_OP_IMM_32: begin
            rs1_used = 1'b1; wen_cls = 1'b1; fmt = IMM_I; op2_imm = 1'b1;
            case (f3)
               F3_ADD_SUB: alu5 = ALU_OP_ADD;
               F3_SLL:     begin alu5 = ALU_OP_SLL; ill_d = (f7 != F7_BASE); end
               F3_SRL_SRA: begin
                  alu5  = (f7 == F7_ALT) ? ALU_OP_SRA : ALU_OP_SRL;
                  ill_d = (f7 != F7_BASE) && (f7 != F7_ALT);
               end
               default:    ill_d = 1'b1;
            endcase
            alu5 = alu5 | ALU_OP_W_FLAG;
            if (!RV64) ill_d = 1'b1;
         end
         INST_TYPE_OP_32: begin
            rs1_used = 1'b1; rs2_used = 1'b1; wen_cls = 1'b1;
            case (f3)
               F3_ADD_SUB: begin
                  alu5  = (f7 == F7_ALT) ? ALU_OP_SUB : ALU_OP_ADD;
                  ill_d = (f7 != F7_BASE) && (f7 != F7_ALT);
               end
               F3_SLL:     begin alu5 = ALU_OP_SLL; ill_d = (f7 != F7_BASE); end
               F3_SRL_SRA: begin
                  alu5  = (f7 == F7_ALT) ? ALU_OP_SRA : ALU_OP_SRL;
                  ill_d = (f7 != F7_BASE) && (f7 != F7_ALT);
               end
               default:    ill_d = 1'b1;
            endcase
            alu5 = alu5 | ALU_OP_W_FLAG;
            if (!RV64) ill_d = 1'b1;
         end
         INST_TYPE_LOAD: begin
            rs1_used = 1'b1; wen_cls = 1'b1; fmt = IMM_I; op2_imm = 1'b1;
            // LD and LWU exist only on RV64
            ill_d = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
         end
         INST_TYPE_STORE: begin
            rs1_used = 1'b1; rs2_used = 1'b1; fmt = IMM_S; op2_imm = 1'b1;
            ill_d = f3[2] || (!RV64 && f3 == 3'b011);
         end
         INST_TYPE_BRANCH: begin
            rs1_used = 1'b1; rs2_used = 1'b1; fmt = IMM_B;
            case (f3)
               3'b000:  alu5 = ALU_OP_BEQ;
               3'b001:  alu5 = ALU_OP_BNE;
               3'b100:  alu5 = ALU_OP_BLT;
               3'b101:  alu5 = ALU_OP_BGE;
               3'b110:  alu5 = ALU_OP_BLTU;
               3'b111:  alu5 = ALU_OP_BGEU;
               default: ill_d = 1'b1;
            endcase
         end
         INST_TYPE_JALR: begin
            rs1_used = 1'b1; wen_cls = 1'b1; fmt = IMM_I; op2_imm = 1'b1;
            ill_d = (f3 != 3'b000);
         end
         INST_TYPE_LUI:   begin wen_cls = 1'b1; fmt = IMM_U; op2_imm = 1'b1; op1_sel = OP1_ZERO; end
         INST_TYPE_AUIPC: begin wen_cls = 1'b1; fmt = IMM_U; op2_imm = 1'b1; op1_sel = OP1_PC; end
         INST_TYPE_JAL:   begin wen_cls = 1'b1; fmt = IMM_J; op2_imm = 1'b1; op1_sel = OP1_PC; end
         default:         ill_d = 1'b1;
      endcase
      // Illegal instructions read nothing and write nothing
      if (ill_d) begin
         rs1_used = 1'b0;
         rs2_used = 1'b0;
         wen_cls  = 1'b0;
      end
   end

   id_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst_i (inst_i),
      .fmt_i  (fmt),
      .imm_o  (imm_d)
   );

   assign rs1_addr_o = rs1_used ? inst_i[19:15] : 5'd0;
   assign rs2_addr_o = rs2_used ? inst_i[24:20] : 5'd0;
   assign wen_d      = wen_cls && (inst_i[11:7] != 5'd0);
   assign rd_d       = wen_d ? inst_i[11:7] : 5'd0;

   // Operand selection
   always_comb begin
      case (op1_sel)
         OP1_PC:   op1_d = inst_addr_i;
         OP1_ZERO: op1_d = '0;
         default:  op1_d = rs1_data_i;
      endcase
      op2_d = op2_imm ? imm_d : rs2_data_i;
   end

   // Load-use hazard: stall while EX's load targets a register this instruction reads
   assign hazard = ex_load_i && (ex_rd_i != 5'd0) &&
                   ((rs1_used && ex_rd_i == inst_i[19:15]) || (rs2_used && ex_rd_i == inst_i[24:20]));

   assign in_ready = !rst && (!valid_q || out_if.out_ready) && !hazard;
   assign accept   = in_valid && in_ready && !flush_i;

   // Output pipeline register: flush kills, accept loads, downstream take empties, else hold
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         addr_q  <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         imm_q   <= '0;
         rd_q    <= '0;
         wen_q   <= 1'b0;
         alu_q   <= '0;
         ill_q   <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         inst_q  <= inst_i;
         addr_q  <= inst_addr_i;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         imm_q   <= imm_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
         alu_q   <= ALU_OP_W'(alu5);
         ill_q   <= ill_d;
      end else if (out_if.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_if.out_valid   = valid_q;
   assign out_if.inst_o      = inst_q;
   assign out_if.inst_addr_o = addr_q;
   assign out_if.op1_o       = op1_q;
   assign out_if.op2_o       = op2_q;
   assign out_if.imm_o       = imm_q;
   assign out_if.rd_addr_o   = rd_q;
   assign out_if.reg_wen_o   = wen_q;
   assign out_if.alu_op_o    = alu_q;
   assign out_if.illegal_o   = ill_q;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: RV64 and RV32 instances on shared stimulus, scoreboarded per width.
module tb_id_stage;

   typedef struct packed {
      logic [63:0] inst, pc, op1, op2, imm;
      logic [4:0]  rd, alu;
      logic        wen, ill, u1, u2, wcls;
   } exp_t;

   localparam int NV = 16;

   logic        clk = 1'b0;
   logic        rst, in_valid, ex_load, flush, out_ready;
   logic [31:0] inst;
   logic [63:0] pc, r1, r2;
   logic [4:0]  ex_rd, cur_alu;
   logic        cur_ill64, cur_ill32;

   logic        in_ready64, in_ready32;
   logic [4:0]  rs1a64, rs2a64, rs1a32, rs2a32;

   logic [31:0] v_inst  [NV];
   logic [4:0]  v_alu   [NV];
   logic        v_ill64 [NV];
   logic        v_ill32 [NV];

   int   n_checks = 0;
   int   n_errors = 0;
   bit   mv64, mv32;
   exp_t q64[$];
   exp_t q32[$];

   always #5 clk = ~clk;

   id_stage_if #(.XLEN(64), .ALU_OP_W(5)) if64 ();
   id_stage_if #(.XLEN(32), .ALU_OP_W(5)) if32 ();
   assign if64.out_ready = out_ready;
   assign if32.out_ready = out_ready;

   id_stage #(.XLEN(64), .ALU_OP_W(5)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
      .inst_i(inst), .inst_addr_i(pc), .rs1_addr_o(rs1a64), .rs2_addr_o(rs2a64),
      .rs1_data_i(r1), .rs2_data_i(r2), .ex_load_i(ex_load), .ex_rd_i(ex_rd),
      .flush_i(flush), .out_if(if64)
   );

   id_stage #(.XLEN(32), .ALU_OP_W(5)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .inst_i(inst), .inst_addr_i(pc[31:0]), .rs1_addr_o(rs1a32), .rs2_addr_o(rs2a32),
      .rs1_data_i(r1[31:0]), .rs2_data_i(r2[31:0]), .ex_load_i(ex_load), .ex_rd_i(ex_rd),
      .flush_i(flush), .out_if(if32)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference decode: operand/immediate behaviour by opcode class, legality from the table
   function automatic exp_t model(input logic [31:0] i, input logic [63:0] p, input logic [63:0] a,
                                  input logic [63:0] b, input logic ill, input logic [4:0] alu,
                                  input bit w32);
      exp_t e;
      logic [63:0] ii, is, ib, iu, ij;
      ii = {{52{i[31]}}, i[31:20]};
      is = {{52{i[31]}}, i[31:25], i[11:7]};
      ib = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      iu = {{32{i[31]}}, i[31:12], 12'b0};
      ij = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      e = '0;
      e.inst = {32'b0, i};
      e.pc   = p;
      e.ill  = ill;
      e.alu  = alu;
      e.rd   = i[11:7];
      case (i[6:0])
         7'h13, 7'h1B, 7'h03, 7'h67: begin e.op1 = a; e.imm = ii; e.op2 = ii; e.u1 = 1; e.wcls = 1; end
         7'h33, 7'h3B:               begin e.op1 = a; e.op2 = b; e.u1 = 1; e.u2 = 1; e.wcls = 1; end
         7'h23:                      begin e.op1 = a; e.imm = is; e.op2 = is; e.u1 = 1; e.u2 = 1; end
         7'h63:                      begin e.op1 = a; e.imm = ib; e.op2 = b; e.u1 = 1; e.u2 = 1; end
         7'h37:                      begin e.op1 = 0; e.imm = iu; e.op2 = iu; e.wcls = 1; end
         7'h17:                      begin e.op1 = p; e.imm = iu; e.op2 = iu; e.wcls = 1; end
         7'h6F:                      begin e.op1 = p; e.imm = ij; e.op2 = ij; e.wcls = 1; end
         default: ;
      endcase
      if (ill) begin e.u1 = 0; e.u2 = 0; e.wcls = 0; end
      e.wen = e.wcls && (i[11:7] != 5'd0);
      if (w32) begin
         e.op1 = {32'b0, e.op1[31:0]};
         e.op2 = {32'b0, e.op2[31:0]};
         e.imm = {32'b0, e.imm[31:0]};
         e.pc  = {32'b0, e.pc[31:0]};
      end
      return e;
   endfunction

   task automatic cmp_out(input string t, input bit mv, input exp_t f, input logic ov,
                          input logic [63:0] oinst, input logic [63:0] opc, input logic [63:0] o1,
                          input logic [63:0] o2, input logic [63:0] oimm, input logic [4:0] ord,
                          input logic owen, input logic [4:0] oalu, input logic oill);
      chk({t, ".out_valid"}, {63'b0, ov}, {63'b0, mv});
      if (mv) begin
         chk({t, ".inst"}, oinst, f.inst);
         chk({t, ".pc"}, opc, f.pc);
         chk({t, ".illegal"}, {63'b0, oill}, {63'b0, f.ill});
         chk({t, ".wen"}, {63'b0, owen}, {63'b0, f.wen});
         if (!f.ill) begin
            chk({t, ".op1"}, o1, f.op1);
            chk({t, ".op2"}, o2, f.op2);
            chk({t, ".imm"}, oimm, f.imm);
            chk({t, ".alu"}, {59'b0, oalu}, {59'b0, f.alu});
         end
         if (f.wcls) chk({t, ".rd"}, {59'b0, ord}, {59'b0, f.rd});
      end
   endtask

   // One clock: check combinational handshake and registered outputs, then advance the model
   task automatic step();
      exp_t e64, e32, f64, f32;
      bit   hz64, hz32, rdy64, rdy32, acc;
      #1;
      e64  = model(inst, pc, r1, r2, cur_ill64, cur_alu, 1'b0);
      e32  = model(inst, pc, r1, r2, cur_ill32, cur_alu, 1'b1);
      hz64 = ex_load && ex_rd != 0 && ((e64.u1 && ex_rd == inst[19:15]) || (e64.u2 && ex_rd == inst[24:20]));
      hz32 = ex_load && ex_rd != 0 && ((e32.u1 && ex_rd == inst[19:15]) || (e32.u2 && ex_rd == inst[24:20]));
      rdy64 = !rst && (!mv64 || out_ready) && !hz64;
      rdy32 = !rst && (!mv32 || out_ready) && !hz32;
      chk("in_ready64", {63'b0, in_ready64}, {63'b0, rdy64});
      chk("in_ready32", {63'b0, in_ready32}, {63'b0, rdy32});
      chk("rs1_addr64", {59'b0, rs1a64}, e64.u1 ? {59'b0, inst[19:15]} : 64'd0);
      chk("rs2_addr64", {59'b0, rs2a64}, e64.u2 ? {59'b0, inst[24:20]} : 64'd0);
      chk("rs1_addr32", {59'b0, rs1a32}, e32.u1 ? {59'b0, inst[19:15]} : 64'd0);
      f64 = (q64.size() != 0) ? q64[0] : '0;
      f32 = (q32.size() != 0) ? q32[0] : '0;
      cmp_out("x64", mv64, f64, if64.out_valid, {32'b0, if64.inst_o}, if64.inst_addr_o, if64.op1_o,
              if64.op2_o, if64.imm_o, if64.rd_addr_o, if64.reg_wen_o, if64.alu_op_o, if64.illegal_o);
      cmp_out("x32", mv32, f32, if32.out_valid, {32'b0, if32.inst_o}, {32'b0, if32.inst_addr_o},
              {32'b0, if32.op1_o}, {32'b0, if32.op2_o}, {32'b0, if32.imm_o}, if32.rd_addr_o,
              if32.reg_wen_o, if32.alu_op_o, if32.illegal_o);
      @(posedge clk);
      if (rst || flush) begin
         mv64 = 0; q64.delete();
         mv32 = 0; q32.delete();
      end else begin
         if (mv64 && out_ready) void'(q64.pop_front());
         acc = in_valid && rdy64;
         if (acc) q64.push_back(e64);
         mv64 = acc || (mv64 && !out_ready);
         if (mv32 && out_ready) void'(q32.pop_front());
         acc = in_valid && rdy32;
         if (acc) q32.push_back(e32);
         mv32 = acc || (mv32 && !out_ready);
      end
      @(negedge clk);
   endtask

   task automatic drive(input int idx, input logic v);
      in_valid  = v;
      inst      = v_inst[idx];
      cur_alu   = v_alu[idx];
      cur_ill64 = v_ill64[idx];
      cur_ill32 = v_ill32[idx];
      pc        = {$urandom, $urandom} & ~64'h3;
      r1        = {$urandom, $urandom};
      r2        = {$urandom, $urandom};
   endtask

   initial begin
      v_inst  = '{32'hFFF10093, 32'h002081B3, 32'h123452B7, 32'h800002B7,
                  32'h40628233, 32'hFE208EE3, 32'h010000EF, 32'h00001397,
                  32'h0010809B, 32'h02009093, 32'h00000000, 32'h00000013,
                  32'h0020A423, 32'h02208133, 32'h0000B183, 32'h4020D093};
      v_alu   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd10, 5'd0, 5'd0,
                  5'd16, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7};
      v_ill64 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
      v_ill32 = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
      mv64 = 0; mv32 = 0;
      rst = 1; ex_load = 0; ex_rd = 0; flush = 0; out_ready = 1;
      drive(0, 1'b1);

      // Reset: outputs cleared, in_ready low while reset is asserted
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.out_valid", {63'b0, if64.out_valid}, 64'd0);
      chk("rst.inst", {32'b0, if64.inst_o}, 64'd0);
      chk("rst.pc", if64.inst_addr_o, 64'd0);
      chk("rst.op1", if64.op1_o, 64'd0);
      chk("rst.op2", if64.op2_o, 64'd0);
      chk("rst.imm", if64.imm_o, 64'd0);
      chk("rst.rd", {59'b0, if64.rd_addr_o}, 64'd0);
      chk("rst.wen", {63'b0, if64.reg_wen_o}, 64'd0);
      chk("rst.alu", {59'b0, if64.alu_op_o}, 64'd0);
      chk("rst.illegal", {63'b0, if64.illegal_o}, 64'd0);
      chk("rst.out_valid32", {63'b0, if32.out_valid}, 64'd0);
      step();
      rst = 0;

      // Every vector once, back to back with a free output
      for (int k = 0; k < NV; k++) begin
         drive(k, 1'b1);
         if (k == 0) r1 = 64'd5;
         step();
      end
      drive(0, 1'b0);
      step();

      // Load-use hazard on rs2, then released
      drive(1, 1'b1);
      ex_load = 1; ex_rd = 5'd2;
      step();
      step();
      ex_rd = 5'd0;            // x0 never creates a hazard
      step();
      ex_load = 0;
      drive(0, 1'b0);
      step();

      // Downstream stall for three cycles with input pending, then release
      drive(2, 1'b1);
      step();
      out_ready = 0;
      for (int k = 3; k < 6; k++) begin
         drive(k, 1'b1);
         step();
      end
      out_ready = 1;
      drive(6, 1'b1);
      step();
      drive(7, 1'b1);
      step();

      // Flush with a held output and a pending input, plus a hazard present
      drive(3, 1'b1);
      out_ready = 0;
      step();
      drive(1, 1'b1);
      ex_load = 1; ex_rd = 5'd1; flush = 1;
      step();
      flush = 0; ex_load = 0; out_ready = 1;
      drive(0, 1'b0);
      step();
      step();

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         drive($urandom_range(0, NV - 1), ($urandom_range(0, 3) != 0));
         out_ready = ($urandom_range(0, 3) != 0);
         ex_load   = ($urandom_range(0, 3) == 0);
         ex_rd     = 5'($urandom_range(0, 6));
         flush     = ($urandom_range(0, 15) == 0);
         step();
      end
      flush = 0; ex_load = 0; out_ready = 1;
      drive(0, 1'b0);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
